// File: rtl/xnor_prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xnor_prbs_pkg
// Description : Shared constants and state type for the XNOR PRBS7 checker.
//               PRBS7 polynomial x^7 + x^6 + 1, XNOR feedback form.
// Revision    : 1.0 - initial release
// ============================================================================
package xnor_prbs_pkg;

    localparam int PRBS_LEN = 7;
    localparam int TAP_HI   = 6;
    localparam int TAP_LO   = 5;

    // All-ones is the XNOR LFSR lockup state: feedback regenerates a 1 forever.
    localparam logic [PRBS_LEN-1:0] LOCKUP_VAL = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED  = 2'd1,
        ST_TRACK = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

endpackage : xnor_prbs_pkg
`default_nettype wire

// File: rtl/xnor_prbs_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : xnor_prbs_checker_if
// Description : Control / status bundle of the PRBS7 checker.
//               master : test source and readout side (drives i_*)
//               slave  : checker side (drives o_*)
//   i_en        checker enable, low forces IDLE
//   i_din       received serial bit
//   i_din_valid qualifier for i_din
//   i_clr       synchronous clear of error/bit counters and saturation flag
//   o_locked    high while the checker is locked
//   o_err_cnt   saturating mismatch count while locked
//   o_bit_cnt   saturating compared-bit count while locked
//   o_err_sat   o_err_cnt is all-ones
// CNT_W must match the CNT_W of the checker attached to the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface xnor_prbs_checker_if #(
    parameter int CNT_W = 16
) ();

    logic             i_en;
    logic             i_din;
    logic             i_din_valid;
    logic             i_clr;
    logic             o_locked;
    logic [CNT_W-1:0] o_err_cnt;
    logic [CNT_W-1:0] o_bit_cnt;
    logic             o_err_sat;

    modport master (
        output i_en, i_din, i_din_valid, i_clr,
        input  o_locked, o_err_cnt, o_bit_cnt, o_err_sat
    );

    modport slave (
        input  i_en, i_din, i_din_valid, i_clr,
        output o_locked, o_err_cnt, o_bit_cnt, o_err_sat
    );

endinterface : xnor_prbs_checker_if
`default_nettype wire

// File: rtl/xnor_prbs7_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : xnor_prbs7_lfsr
// Description : 7-bit XNOR-feedback LFSR producing the expected PRBS7 bit.
//               On i_adv the register shifts left, taking i_load_bit when
//               i_load_sel is high (seeding) or its own expected bit otherwise.
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset (clears register to 0)
//   i_adv       shift enable
//   i_load_sel  1: shift in i_load_bit, 0: shift in o_exp
//   i_load_bit  external bit used while seeding
//   o_exp       expected next bit, ~(s[6] ^ s[5])
//   o_state     current register contents
// Revision    : 1.0 - initial release
// ============================================================================
module xnor_prbs7_lfsr
    import xnor_prbs_pkg::*;
(
    input  wire logic                i_clk,
    input  wire logic                i_rst_n,
    input  wire logic                i_adv,
    input  wire logic                i_load_sel,
    input  wire logic                i_load_bit,
    output logic                     o_exp,
    output logic [PRBS_LEN-1:0]      o_state
);

    logic [PRBS_LEN-1:0] r_state;
    logic                w_exp;
    logic                w_in_bit;

    assign w_exp    = ~(r_state[TAP_HI] ^ r_state[TAP_LO]);
    assign w_in_bit = i_load_sel ? i_load_bit : w_exp;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= '0;
        end else if (i_adv) begin
            r_state <= {r_state[PRBS_LEN-2:0], w_in_bit};
        end
    end

    assign o_exp   = w_exp;
    assign o_state = r_state;

endmodule : xnor_prbs7_lfsr
`default_nettype wire

// File: rtl/xnor_prbs_checker.sv
`default_nettype none
// ============================================================================
// Module      : xnor_prbs_checker
// Description : Serial PRBS7 (XNOR, x^7+x^6+1) bit-error checker. Seeds its
//               LFSR from the incoming stream, qualifies lock over LOCK_COUNT
//               consecutive matches, then counts compared bits and errors.
//               LOSS_COUNT consecutive errors while locked force a reseed.
//   i_clk       clock, all state updates on the rising edge
//   i_rst_n     asynchronous active-low reset
//   bus         xnor_prbs_checker_if.slave (enable, data, clear, status)
// Revision    : 1.0 - initial release
// ============================================================================
module xnor_prbs_checker
    import xnor_prbs_pkg::*;
#(
    parameter int LOCK_COUNT = 16,
    parameter int LOSS_COUNT = 4,
    parameter int CNT_W      = 16
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst_n,
    xnor_prbs_checker_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]       c_seed_last = 3'(PRBS_LEN - 1);
    localparam logic [7:0]       c_lock_last = 8'(LOCK_COUNT - 1);
    localparam logic [7:0]       c_loss_last = 8'(LOSS_COUNT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_seed_cnt;
    logic [2:0]          w_seed_cnt_nxt;
    logic [7:0]          r_run_cnt;
    logic [7:0]          w_run_cnt_nxt;
    logic [7:0]          r_loss_cnt;
    logic [7:0]          w_loss_cnt_nxt;

    logic [CNT_W-1:0]    r_err_cnt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic                r_err_sat;
    logic                r_locked;
    logic [CNT_W-1:0]    w_err_cnt_nxt;
    logic [CNT_W-1:0]    w_bit_cnt_nxt;
    logic                w_err_sat_nxt;
    logic                w_locked_nxt;

    logic                w_exp;
    logic [PRBS_LEN-1:0] w_lfsr_state;
    logic [PRBS_LEN-1:0] w_seed_val;
    logic                w_match;
    logic                w_lfsr_adv;
    logic                w_count_en;

    // ------------------------------------------------------------------------
    // Expected-sequence generator
    // ------------------------------------------------------------------------
    assign w_lfsr_adv = bus.i_en && bus.i_din_valid && (r_state != ST_IDLE);

    xnor_prbs7_lfsr u_lfsr (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_adv      (w_lfsr_adv),
        .i_load_sel (r_state == ST_SEED),
        .i_load_bit (bus.i_din),
        .o_exp      (w_exp),
        .o_state    (w_lfsr_state)
    );

    assign w_match    = ~(w_exp ^ bus.i_din);
    // Register contents after this seeding shift; all-ones would lock the
    // XNOR generator, so seeding is not allowed to complete on it.
    assign w_seed_val = (w_lfsr_state << 1) | {{(PRBS_LEN-1){1'b0}}, bus.i_din};
    assign w_count_en = bus.i_en && bus.i_din_valid && (r_state == ST_LOCK);

    // ------------------------------------------------------------------------
    // State register (with seed / run / loss qualifiers)
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_seed_cnt <= '0;
            r_run_cnt  <= '0;
            r_loss_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_seed_cnt <= w_seed_cnt_nxt;
            r_run_cnt  <= w_run_cnt_nxt;
            r_loss_cnt <= w_loss_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_seed_cnt_nxt = r_seed_cnt;
        w_run_cnt_nxt  = r_run_cnt;
        w_loss_cnt_nxt = r_loss_cnt;

        if (!bus.i_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt    = ST_SEED;
                    w_seed_cnt_nxt = '0;
                end
                ST_SEED: begin
                    if (bus.i_din_valid) begin
                        if (r_seed_cnt == c_seed_last) begin
                            // Seventh bit: finish seeding unless the loaded
                            // value is the lockup state, then keep sampling.
                            if (w_seed_val != LOCKUP_VAL) begin
                                w_state_nxt   = ST_TRACK;
                                w_run_cnt_nxt = '0;
                            end
                        end else begin
                            w_seed_cnt_nxt = r_seed_cnt + 3'd1;
                        end
                    end
                end
                ST_TRACK: begin
                    if (bus.i_din_valid) begin
                        if (w_match) begin
                            if (r_run_cnt == c_lock_last) begin
                                w_state_nxt    = ST_LOCK;
                                w_loss_cnt_nxt = '0;
                            end else begin
                                w_run_cnt_nxt = r_run_cnt + 8'd1;
                            end
                        end else begin
                            w_state_nxt    = ST_SEED;
                            w_seed_cnt_nxt = '0;
                        end
                    end
                end
                ST_LOCK: begin
                    if (bus.i_din_valid) begin
                        if (w_match) begin
                            w_loss_cnt_nxt = '0;
                        end else if (r_loss_cnt == c_loss_last) begin
                            w_state_nxt    = ST_SEED;
                            w_seed_cnt_nxt = '0;
                        end else begin
                            w_loss_cnt_nxt = r_loss_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output logic: next values of the registered status outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_err_cnt_nxt = r_err_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        if (bus.i_clr) begin
            // Clear wins over a bit compared in the same cycle.
            w_err_cnt_nxt = '0;
            w_bit_cnt_nxt = '0;
        end else if (w_count_en) begin
            if (!(&r_bit_cnt)) begin
                w_bit_cnt_nxt = r_bit_cnt + c_cnt_one;
            end
            if (!w_match && !(&r_err_cnt)) begin
                w_err_cnt_nxt = r_err_cnt + c_cnt_one;
            end
        end
        w_err_sat_nxt = &w_err_cnt_nxt;
        w_locked_nxt  = (w_state_nxt == ST_LOCK);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt <= '0;
            r_bit_cnt <= '0;
            r_err_sat <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_err_cnt <= w_err_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_err_sat <= w_err_sat_nxt;
            r_locked  <= w_locked_nxt;
        end
    end

    assign bus.o_locked  = r_locked;
    assign bus.o_err_cnt = r_err_cnt;
    assign bus.o_bit_cnt = r_bit_cnt;
    assign bus.o_err_sat = r_err_sat;

endmodule : xnor_prbs_checker
`default_nettype wire

// File: tb/tb_xnor_prbs_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_xnor_prbs_checker
// Description : Self-checking bench for xnor_prbs_checker. Instance A
//               (CNT_W=16, LOSS_COUNT=4) is compared every cycle against a
//               behavioural model; instance B (CNT_W=4) exercises saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xnor_prbs_checker;

    localparam int LOCK_A = 16;
    localparam int LOSS_A = 4;
    localparam int MAX_A  = 65535;

    localparam int M_IDLE  = 0;
    localparam int M_SEED  = 1;
    localparam int M_TRACK = 2;
    localparam int M_LOCK  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xnor_prbs_checker_if #(.CNT_W(16)) if_a ();
    xnor_prbs_checker_if #(.CNT_W(4))  if_b ();

    xnor_prbs_checker #(.LOCK_COUNT(16), .LOSS_COUNT(4), .CNT_W(16)) u_dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if_a)
    );

    xnor_prbs_checker #(.LOCK_COUNT(16), .LOSS_COUNT(255), .CNT_W(4)) u_dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if_b)
    );

    int total = 0;
    int bad   = 0;
    bit en_a, clr_a, en_b, clr_b;

    // ---------------- behavioural model of instance A ----------------------
    // The reference sequence obeys x[n] = ~(x[n-7] ^ x[n-6]); m_hist keeps the
    // last seven sequence bits, oldest first. Counts are unbounded and clipped
    // at compare time.
    int m_mode;
    bit m_hist[$];
    int m_seeded, m_run, m_loss;
    int m_err, m_bits;

    // stimulus generator: clean PRBS7 from an all-zero history
    bit g_hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clip(input int v);
        return (v > MAX_A) ? MAX_A : v;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_hist.delete();
        repeat (7) m_hist.push_back(1'b0);
        m_seeded = 0; m_run = 0; m_loss = 0;
        m_err = 0; m_bits = 0;
    endtask

    task automatic model_step(input bit en, input bit din, input bit vld, input bit clr);
        bit e;
        int ones;
        if (!en) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_SEED;
            m_seeded = 0;
        end else if (vld) begin
            if (m_mode == M_SEED) begin
                m_hist.push_back(din);
                void'(m_hist.pop_front());
                m_seeded++;
                if (m_seeded >= 7) begin
                    ones = 0;
                    foreach (m_hist[k]) ones += int'(m_hist[k]);
                    if (ones == 7) m_seeded = 6;
                    else begin m_mode = M_TRACK; m_run = 0; end
                end
            end else begin
                e = !(m_hist[0] ^ m_hist[1]);
                m_hist.push_back(e);
                void'(m_hist.pop_front());
                if (m_mode == M_TRACK) begin
                    if (din == e) begin
                        m_run++;
                        if (m_run == LOCK_A) begin m_mode = M_LOCK; m_loss = 0; end
                    end else begin
                        m_mode = M_SEED; m_seeded = 0;
                    end
                end else begin
                    m_bits++;
                    if (din != e) begin
                        m_err++;
                        m_loss++;
                        if (m_loss == LOSS_A) begin m_mode = M_SEED; m_seeded = 0; end
                    end else begin
                        m_loss = 0;
                    end
                end
            end
        end
        if (clr) begin m_err = 0; m_bits = 0; end
    endtask

    task automatic gen_reset();
        g_hist.delete();
        repeat (7) g_hist.push_back(1'b0);
    endtask

    task automatic gen_next(output bit b);
        b = !(g_hist[0] ^ g_hist[1]);
        g_hist.push_back(b);
        void'(g_hist.pop_front());
    endtask

    // ---------------- stimulus helpers --------------------------------------
    task automatic cyc(input bit din, input bit vld);
        if_a.i_en = en_a; if_a.i_clr = clr_a; if_a.i_din = din; if_a.i_din_valid = vld;
        if_b.i_en = en_b; if_b.i_clr = clr_b; if_b.i_din = din; if_b.i_din_valid = vld;
        @(posedge clk);
        if (rst_n) model_step(en_a, din, vld, clr_a);
        #1;
    endtask

    task automatic feed_clean(input int n, input int gap);
        bit b;
        for (int i = 0; i < n; i++) begin
            repeat (gap) cyc(1'($urandom_range(0, 1)), 1'b0);
            gen_next(b);
            cyc(b, 1'b1);
        end
    endtask

    task automatic feed_bad(input int n);
        bit b;
        for (int i = 0; i < n; i++) begin
            gen_next(b);
            cyc(!b, 1'b1);
        end
    endtask

    // ---------------- per-cycle compare of instance A -----------------------
    initial begin
        forever begin
            @(negedge clk);
            check("a_locked",  {31'd0, if_a.o_locked},  {31'd0, (m_mode == M_LOCK)});
            check("a_err_cnt", {16'd0, if_a.o_err_cnt}, clip(m_err));
            check("a_bit_cnt", {16'd0, if_a.o_bit_cnt}, clip(m_bits));
            check("a_err_sat", {31'd0, if_a.o_err_sat}, {31'd0, (clip(m_err) == MAX_A)});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed and random stimulus --------------------------
    initial begin
        bit b;
        logic [7:0] first8;
        int burst;
        bit e_bit, v_bit;

        en_a = 0; clr_a = 0; en_b = 0; clr_b = 0;
        if_a.i_en = 0; if_a.i_clr = 0; if_a.i_din = 0; if_a.i_din_valid = 0;
        if_b.i_en = 0; if_b.i_clr = 0; if_b.i_din = 0; if_b.i_din_valid = 0;
        model_reset();

        // generator sanity: x0..x7 of the XNOR PRBS7 from zero are 1111_1101
        gen_reset();
        for (int i = 0; i < 8; i++) begin gen_next(b); first8 = {first8[6:0], b}; end
        check("gen_first8", {24'd0, first8}, 32'h0000_00FD);

        repeat (3) cyc(1'b0, 1'b0);
        check("rst_a_locked", {31'd0, if_a.o_locked}, 0);
        check("rst_b_err",    {28'd0, if_b.o_err_cnt}, 0);
        #2 rst_n = 1'b1;

        // ---- saturation on the 4-bit instance B ----
        en_b = 1; cyc(1'b0, 1'b0);
        gen_reset();
        feed_clean(23, 0);
        check("b_locked",     {31'd0, if_b.o_locked}, 1);
        feed_bad(14);
        check("b_err14",      {28'd0, if_b.o_err_cnt}, 14);
        check("b_sat14",      {31'd0, if_b.o_err_sat}, 0);
        feed_bad(1);
        check("b_err15",      {28'd0, if_b.o_err_cnt}, 15);
        check("b_sat15",      {31'd0, if_b.o_err_sat}, 1);
        feed_bad(5);
        check("b_err_stick",  {28'd0, if_b.o_err_cnt}, 15);
        check("b_bit_stick",  {28'd0, if_b.o_bit_cnt}, 15);
        check("b_still_lock", {31'd0, if_b.o_locked}, 1);
        clr_b = 1; feed_bad(1); clr_b = 0;
        check("b_clr_err",    {28'd0, if_b.o_err_cnt}, 0);
        check("b_clr_sat",    {31'd0, if_b.o_err_sat}, 0);
        check("b_clr_bit",    {28'd0, if_b.o_bit_cnt}, 0);
        feed_bad(1);
        check("b_err_after",  {28'd0, if_b.o_err_cnt}, 1);
        en_b = 0; cyc(1'b0, 1'b0);
        check("b_en_unlock",  {31'd0, if_b.o_locked}, 0);
        check("b_en_hold",    {28'd0, if_b.o_err_cnt}, 1);

        // ---- clean lock-up and 1000 counted bits ----
        en_a = 1; cyc(1'b0, 1'b0);
        gen_reset();
        feed_clean(22, 0);
        check("t1_nolock22", {31'd0, if_a.o_locked}, 0);
        feed_clean(1, 0);
        check("t1_lock23",   {31'd0, if_a.o_locked}, 1);
        feed_clean(1000, 0);
        check("t1_bits",     {16'd0, if_a.o_bit_cnt}, 1000);
        check("t1_errs",     {16'd0, if_a.o_err_cnt}, 0);

        // ---- isolated errors ----
        repeat (3) begin feed_clean(10, 0); feed_bad(1); end
        feed_clean(10, 0);
        check("t2_errs",   {16'd0, if_a.o_err_cnt}, 3);
        check("t2_locked", {31'd0, if_a.o_locked}, 1);

        // ---- loss of lock on a burst and relock ----
        clr_a = 1; cyc(1'b0, 1'b0); clr_a = 0;
        feed_bad(3);
        check("t3_lock3",   {31'd0, if_a.o_locked}, 1);
        feed_bad(1);
        check("t3_unlock4", {31'd0, if_a.o_locked}, 0);
        check("t3_err4",    {16'd0, if_a.o_err_cnt}, 4);
        feed_clean(22, 0);
        check("t3_nolock",  {31'd0, if_a.o_locked}, 0);
        feed_clean(1, 0);
        check("t3_relock",  {31'd0, if_a.o_locked}, 1);
        check("t3_err_kept",{16'd0, if_a.o_err_cnt}, 4);

        // ---- lockup seed must not complete seeding ----
        en_a = 0; cyc(1'b0, 1'b0);
        en_a = 1; cyc(1'b0, 1'b0);
        repeat (7) cyc(1'b1, 1'b1);
        gen_reset();
        feed_clean(22, 0);
        check("t4_nolock", {31'd0, if_a.o_locked}, 0);
        feed_clean(1, 0);
        check("t4_lock",   {31'd0, if_a.o_locked}, 1);

        // ---- sparse valid, EN drops, reset pulse ----
        clr_a = 1; cyc(1'b0, 1'b0); clr_a = 0;
        en_a = 0; cyc(1'b0, 1'b0);
        en_a = 1; cyc(1'b0, 1'b0);
        feed_clean(22, 2);
        check("t6_nolock_sparse", {31'd0, if_a.o_locked}, 0);
        feed_clean(1, 2);
        check("t6_lock_sparse",   {31'd0, if_a.o_locked}, 1);
        feed_clean(5, 0);
        en_a = 0; cyc(1'b0, 1'b0);
        check("t6_en_unlock", {31'd0, if_a.o_locked}, 0);
        check("t6_en_hold",   {16'd0, if_a.o_bit_cnt}, 5);
        en_a = 1; cyc(1'b0, 1'b0);
        feed_clean(10, 0);
        en_a = 0; gen_next(b); cyc(b, 1'b1);
        check("t6_track_drop", {31'd0, if_a.o_locked}, 0);
        check("t6_track_hold", {16'd0, if_a.o_bit_cnt}, 5);
        en_a = 1; cyc(1'b0, 1'b0);
        feed_clean(22, 0);
        check("t6_nolock2", {31'd0, if_a.o_locked}, 0);
        feed_clean(1, 0);
        check("t6_relock",  {31'd0, if_a.o_locked}, 1);
        feed_clean(7, 0);
        check("t6_bits12",  {16'd0, if_a.o_bit_cnt}, 12);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_locked", {31'd0, if_a.o_locked}, 0);
        check("t6_rst_bits",   {16'd0, if_a.o_bit_cnt}, 0);
        repeat (2) cyc(1'b0, 1'b0);
        #2 rst_n = 1'b1;

        // ---- randomized traffic against the model ----
        burst = 0;
        gen_reset();
        for (int i = 0; i < 3000; i++) begin
            en_a  = ($urandom_range(0, 299) != 0);
            clr_a = ($urandom_range(0, 199) == 0);
            v_bit = ($urandom_range(0, 3) != 0);
            if (burst == 0 && $urandom_range(0, 399) == 0) burst = $urandom_range(2, 6);
            if (v_bit) begin
                gen_next(b);
                e_bit = (burst > 0) || ($urandom_range(0, 39) == 0);
                if (burst > 0) burst--;
                cyc(b ^ e_bit, 1'b1);
            end else begin
                cyc(1'($urandom_range(0, 1)), 1'b0);
            end
        end
        clr_a = 0;
        en_a  = 1;
        repeat (3) cyc(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_xnor_prbs_checker
`default_nettype wire
